// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-driven stall and bypass selection for the five-stage pipeline, plus MDU busy tracking.
// Define HAZARD_FWD_EN to build the bypass network; without it every fwd select is 0 and any E/M producer stalls.
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] rs_tuse,
    input  logic [1:0] rt_tuse,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    input  logic       d_md_use,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       req,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic [1:0] fwd_rt_m,
    output logic       md_start
);
    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW = $clog2(MAX_CYC + 1);

    logic [4:0]    e_wa, m_wa;
    logic [1:0]    e_tnew, m_tnew;
    logic          e_start, e_div;
    logic [CW-1:0] cnt;
    logic          rs_hz, rt_hz, md_hz;

    function automatic logic reads(input logic [4:0] s, input logic [1:0] tuse, input logic [4:0] wa);
        return s != 5'd0 && tuse != 2'd3 && wa == s;
    endfunction

`ifdef HAZARD_FWD_EN
    logic [4:0] e_rs, e_rt, m_rt, w_wa;

    // youngest matching producer decides: its select if already produced, otherwise 0 and the stall covers it
    function automatic logic [1:0] pick(
        input logic [4:0] s, input logic ok,
        input logic [4:0] a_wa, input logic [1:0] a_tnew, input logic [1:0] a_sel,
        input logic [4:0] b_wa, input logic [1:0] b_tnew, input logic [1:0] b_sel,
        input logic [4:0] c_wa, input logic [1:0] c_sel
    );
        return (!ok || s == 5'd0) ? 2'd0 :
               (a_wa == s) ? ((a_tnew == 2'd0) ? a_sel : 2'd0) :
               (b_wa == s) ? ((b_tnew == 2'd0) ? b_sel : 2'd0) :
               (c_wa == s) ? c_sel : 2'd0;
    endfunction

    assign rs_hz = (reads(d_rs, rs_tuse, e_wa) && e_tnew > rs_tuse) || (reads(d_rs, rs_tuse, m_wa) && m_tnew > rs_tuse);
    assign rt_hz = (reads(d_rt, rt_tuse, e_wa) && e_tnew > rt_tuse) || (reads(d_rt, rt_tuse, m_wa) && m_tnew > rt_tuse);
    assign fwd_rs_d = pick(d_rs, rs_tuse != 2'd3, e_wa, e_tnew, 2'd1, m_wa, m_tnew, 2'd2, w_wa, 2'd3);
    assign fwd_rt_d = pick(d_rt, rt_tuse != 2'd3, e_wa, e_tnew, 2'd1, m_wa, m_tnew, 2'd2, w_wa, 2'd3);
    assign fwd_rs_e = pick(e_rs, 1'b1, m_wa, m_tnew, 2'd2, w_wa, 2'd0, 2'd3, 5'd0, 2'd0);
    assign fwd_rt_e = pick(e_rt, 1'b1, m_wa, m_tnew, 2'd2, w_wa, 2'd0, 2'd3, 5'd0, 2'd0);
    assign fwd_rt_m = pick(m_rt, 1'b1, w_wa, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);

    // source fields and the W destination exist only to steer the bypass muxes
    always_ff @(posedge clk) begin
        if (reset || req) begin
            e_rs <= '0;
            e_rt <= '0;
            m_rt <= '0;
            w_wa <= '0;
        end else begin
            w_wa <= m_wa;
            m_rt <= e_rt;
            e_rs <= stall ? 5'd0 : d_rs;
            e_rt <= stall ? 5'd0 : d_rt;
        end
    end
`else
    logic unused_tnew;

    assign unused_tnew = ^m_tnew;
    assign rs_hz = reads(d_rs, rs_tuse, e_wa) || reads(d_rs, rs_tuse, m_wa);
    assign rt_hz = reads(d_rt, rt_tuse, e_wa) || reads(d_rt, rt_tuse, m_wa);
    assign fwd_rs_d = 2'd0;
    assign fwd_rt_d = 2'd0;
    assign fwd_rs_e = 2'd0;
    assign fwd_rt_e = 2'd0;
    assign fwd_rt_m = 2'd0;
`endif

    assign md_hz    = d_md_use & (e_start | (cnt != '0));
    assign stall    = rs_hz | rt_hz | md_hz;
    assign md_start = e_start & ~req;

    // advance the scoreboard; req flushes E and M, stall injects a bubble into E
    always_ff @(posedge clk) begin
        if (reset || req) begin
            e_wa    <= '0;
            e_tnew  <= '0;
            e_start <= 1'b0;
            e_div   <= 1'b0;
            m_wa    <= '0;
            m_tnew  <= '0;
        end else begin
            m_wa    <= e_wa;
            m_tnew  <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            e_wa    <= stall ? 5'd0 : d_wa;
            e_tnew  <= stall ? 2'd0 : d_tnew;
            e_start <= stall ? 1'b0 : d_md_start;
            e_div   <= stall ? 1'b0 : d_md_div;
        end
    end

    // MDU busy counter; a flush does not abort an operation already started
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (md_start)
            cnt <= e_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed pipeline scenarios plus randomized traffic checked against an instruction-level model.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] d_rs = '0, d_rt = '0, d_wa = '0;
    logic [1:0] rs_tuse = 2'd3, rt_tuse = 2'd3, d_tnew = '0;
    logic       d_md_use = 1'b0, d_md_start = 1'b0, d_md_div = 1'b0, req = 1'b0;
    logic       stall, md_start;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .rs_tuse(rs_tuse), .rt_tuse(rt_tuse),
        .d_wa(d_wa), .d_tnew(d_tnew), .d_md_use(d_md_use), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .req(req), .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
        .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_start(md_start)
    );

    typedef struct {
        logic [4:0] rs, rt, wa;
        int         tn;
        bit         st, dv;
    } rec_t;

    rec_t p[3];
    rec_t bub;
    int   errors = 0, checks = 0, cyc = 0, busy_end = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Tnew of the instruction k stages past D (0=E, 1=M, 2=W): it counts down one per stage
    function automatic int tn_at(int k);
        int t = p[k].tn - k;
        return t < 0 ? 0 : t;
    endfunction

    function automatic bit src_hz(logic [4:0] s, logic [1:0] tu);
        bit h = 0;
        if (s == 5'd0 || tu == 2'd3) return 0;
        for (int k = 0; k < 2; k++)
            if (p[k].wa == s) begin
`ifdef HAZARD_FWD_EN
                if (tn_at(k) > int'(tu)) h = 1;
`else
                h = 1;
`endif
            end
        return h;
    endfunction

    function automatic int sel_from(logic [4:0] s, int first);
`ifdef HAZARD_FWD_EN
        if (s == 5'd0) return 0;
        for (int k = first; k < 3; k++)
            if (p[k].wa == s) return tn_at(k) == 0 ? k + 1 : 0;
`endif
        return 0;
    endfunction

    function automatic bit m_stall();
        return src_hz(d_rs, rs_tuse) || src_hz(d_rt, rt_tuse) || (d_md_use && (p[0].st || cyc < busy_end));
    endfunction

    task automatic settle();
        @(negedge clk);
        chk("stall", int'(stall), int'(m_stall()));
        chk("md_start", int'(md_start), int'(p[0].st && !req));
        chk("fwd_rs_d", int'(fwd_rs_d), rs_tuse == 2'd3 ? 0 : sel_from(d_rs, 0));
        chk("fwd_rt_d", int'(fwd_rt_d), rt_tuse == 2'd3 ? 0 : sel_from(d_rt, 0));
        chk("fwd_rs_e", int'(fwd_rs_e), sel_from(p[0].rs, 1));
        chk("fwd_rt_e", int'(fwd_rt_e), sel_from(p[0].rt, 1));
        chk("fwd_rt_m", int'(fwd_rt_m), sel_from(p[1].rt, 2));
    endtask

    task automatic adv();
        bit s, ms;
        @(posedge clk);
        s  = m_stall();
        ms = p[0].st && !req;
        cyc++;
        if (reset) begin
            p[0] = bub; p[1] = bub; p[2] = bub;
            busy_end = 0;
        end else begin
            if (ms) busy_end = cyc + (p[0].dv ? 10 : 5);
            if (req) begin
                p[0] = bub; p[1] = bub; p[2] = bub;
            end else begin
                p[2] = p[1];
                p[1] = p[0];
                p[0] = s ? bub : '{d_rs, d_rt, d_wa, int'(d_tnew), d_md_start, d_md_div};
            end
        end
        #1;
    endtask

    task automatic set_d(input int rs, rt, rtu, ttu, wa, tn, mu, ms, md);
        d_rs = 5'(rs); d_rt = 5'(rt); rs_tuse = 2'(rtu); rt_tuse = 2'(ttu);
        d_wa = 5'(wa); d_tnew = 2'(tn);
        d_md_use = mu != 0; d_md_start = ms != 0; d_md_div = md != 0;
    endtask

    task automatic nop();
        set_d(0, 0, 3, 3, 0, 0, 0, 0, 0);
        req = 1'b0;
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < 3; i++) begin
            settle();
            adv();
        end
    endtask

    // counts consecutive stall cycles of the current D instruction (bounded); leaves the bench at a negedge
    task automatic count_stall(output int n, output int starts, output int fo);
        n = 0; starts = 0; fo = 0;
        for (int i = 0; i < 30; i++) begin
            settle();
            if (md_start) starts++;
            if (fwd_rs_d | fwd_rt_d | fwd_rs_e | fwd_rt_e | fwd_rt_m) fo++;
            if (!stall) break;
            n++;
            adv();
        end
    endtask

    initial begin
        int n, st, fo;
        bub = '{5'd0, 5'd0, 5'd0, 0, 1'b0, 1'b0};
        p[0] = bub; p[1] = bub; p[2] = bub;

        set_d(1, 1, 0, 0, 1, 2, 1, 0, 0);
        reset = 1'b1;
        adv();
        adv();
        reset = 1'b0;
        settle();
        chk("rst_stall", int'(stall), 0);
        chk("rst_md_start", int'(md_start), 0);
        chk("rst_fwd", int'(fwd_rs_d | fwd_rt_d | fwd_rs_e | fwd_rt_e | fwd_rt_m), 0);
        adv();
        drain();

`ifdef HAZARD_FWD_EN
        set_d(0, 0, 1, 3, 1, 2, 0, 0, 0);
        settle(); adv();
        set_d(1, 2, 1, 1, 3, 1, 0, 0, 0);
        settle(); chk("lu_stall1", int'(stall), 1); adv();
        settle(); chk("lu_stall2", int'(stall), 0); chk("lu_fwd_rs_d", int'(fwd_rs_d), 0); adv();
        nop();
        settle(); chk("lu_fwd_rs_e", int'(fwd_rs_e), 3); adv();
        drain();

        set_d(0, 0, 1, 1, 2, 1, 0, 0, 0);
        settle(); adv();
        set_d(2, 0, 0, 0, 0, 0, 0, 0, 0);
        settle(); chk("br_stall1", int'(stall), 1); adv();
        settle(); chk("br_stall2", int'(stall), 0); chk("br_fwd_rs_d", int'(fwd_rs_d), 2); adv();
        drain();

        set_d(0, 0, 1, 1, 2, 1, 0, 0, 0);
        settle(); adv();
        set_d(0, 2, 1, 2, 0, 0, 0, 0, 0);
        settle(); chk("sw_stall", int'(stall), 0); adv();
        nop();
        settle(); chk("sw_fwd_rt_e", int'(fwd_rt_e), 2); adv();
        settle(); chk("sw_fwd_rt_m", int'(fwd_rt_m), 3); adv();
        drain();
`else
        set_d(0, 0, 1, 1, 1, 1, 0, 0, 0);
        settle(); adv();
        set_d(1, 2, 1, 1, 3, 1, 0, 0, 0);
        count_stall(n, st, fo);
        chk("nofwd_stall_len", n, 2);
        chk("nofwd_fwd_zero", fo, 0);
        adv();
        drain();
`endif

        for (int dv = 0; dv < 2; dv++) begin
            set_d(0, 0, 1, 1, 0, 0, 1, 1, dv);
            settle(); adv();
            set_d(0, 0, 3, 3, 4, 1, 1, 0, 0);
            count_stall(n, st, fo);
            chk(dv ? "div_stall_len" : "mult_stall_len", n, dv ? 11 : 6);
            chk(dv ? "div_md_start_cnt" : "mult_md_start_cnt", st, 1);
            adv();
            drain();
        end

        set_d(0, 0, 1, 3, 0, 2, 0, 0, 0);
        settle(); adv();
        set_d(0, 0, 1, 1, 3, 1, 0, 0, 0);
        count_stall(n, st, fo);
        chk("zero_stall", n, 0);
        chk("zero_fwd", fo, 0);
        adv();
        drain();

        set_d(0, 0, 1, 3, 1, 2, 0, 0, 0);
        settle(); adv();
        set_d(1, 2, 1, 1, 3, 1, 0, 0, 0);
        req = 1'b1;
        settle(); adv();
        req = 1'b0;
        settle(); chk("exc_stall", int'(stall), 0); chk("exc_fwd_rs_d", int'(fwd_rs_d), 0); adv();
        drain();
        set_d(0, 0, 1, 1, 0, 0, 1, 1, 0);
        settle(); adv();
        nop();
        req = 1'b1;
        settle(); chk("exc_md_start", int'(md_start), 0); adv();
        req = 1'b0;
        set_d(0, 0, 3, 3, 4, 1, 1, 0, 0);
        settle(); chk("exc_mflo_stall", int'(stall), 0); adv();
        drain();

        for (int i = 0; i < 3000; i++) begin
            int mu;
            mu = ($urandom_range(0, 3) == 0) ? 1 : 0;
            set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2), mu, mu & $urandom_range(0, 1), $urandom_range(0, 1));
            req = $urandom_range(0, 19) == 0;
            reset = $urandom_range(0, 99) == 0;
            settle();
            adv();
        end
        reset = 1'b0;
        nop();
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central stall and forwarding scheduler for the five-stage MIPS pipeline. It keeps a scoreboard of in-flight destination registers with their Tnew in stages E, M and W, and compares it against the D-stage instruction's rs/rt Tuse to raise `stall`. It drives the bypass select lines for the D, E and M consumers. It also tracks the multiply/divide unit's busy window so HI/LO instructions wait for it.

## Interface
Parameters:
- `MULT_CYC`, default 5: busy cycles of mult/multu.
- `DIV_CYC`, default 10: busy cycles of div/divu.

Ports:
- `clk` in 1: single clock; every register updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `d_rs`, `d_rt` in 5: D-stage source register numbers.
- `rs_tuse`, `rt_tuse` in 2: Tuse for the D-stage instruction; the value 3 means the register is not read.
- `d_wa` in 5: D-stage destination register (0 = none).
- `d_tnew` in 2: producer's Tnew at stage E (jal=0, ALU=1, load=2).
- `d_md_use` in 1: the D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `d_md_start` in 1: the D instruction is mult/multu/div/divu.
- `d_md_div` in 1: with `d_md_start`, selects DIV_CYC.
- `req` in 1: exception/interrupt taken at M.
- `stall` out 1: freeze PC and the D register; insert a bubble into E.
- `fwd_rs_d`, `fwd_rt_d` out 2: D-stage bypass select. 0 = regfile, 1 = E, 2 = M, 3 = W.
- `fwd_rs_e`, `fwd_rt_e` out 2: E-stage bypass select. 0 = pipeline register, 2 = M, 3 = W.
- `fwd_rt_m` out 2: M-stage store-data bypass select. 0 = pipeline register, 3 = W.
- `md_start` out 1: start pulse to the MDU.

## Operation
- Scoreboard entries E, M, W each hold {rs, rt, wa, tnew, start}. A bubble is all zero.
- Every cycle the entries advance:
  - W ← M, with tnew forced to 0.
  - M ← E, with tnew = max(tnew−1, 0) and start cleared.
  - E ← D inputs, or a bubble if `stall`.
- `req` has priority over `stall`: E, M and W all load bubbles. The old W retires normally.
- Register match for source s against entry X: s≠0, X.wa==s, and the corresponding tuse≠3 (for D-stage checks).
- Stall condition, combinational, for each source s with its Tuse:
  - (E matches and E.tnew > tuse) or (M matches and M.tnew > tuse).
- Forward select rule:
  - The youngest matching producer with tnew==0 wins.
  - D checks E, then M, then W.
  - E-stage checks use E.rs/E.rt against M, then W.
  - The M-stage check uses M.rt against W.
  - A match with tnew>0 yields select 0; the stall covers that case.
- MDU handling:
  - `md_start` = E.start & ~req.
  - On `md_start` the counter `cnt` loads MULT_CYC or DIV_CYC, chosen by the stored div bit.
  - Otherwise `cnt` decrements while nonzero.
  - `req` does not abort a running count.
- MDU stall: `d_md_use` & (E.start | cnt≠0). It is ORed into `stall`.
- Writes to register 0 never create a hazard and are never forwarded.

## Timing
- Reset state: all entries are bubbles and `cnt`=0.
  - Consequently `stall`=0, all fwd selects=0 and `md_start`=0 in the cycle after reset, for any D inputs.
- `stall` and all fwd outputs are combinational from the current entries and the D inputs; there is zero-cycle latency.
- Scoreboard updates are visible one cycle after the edge.
- Simultaneous `reset` and `req`: `reset` wins.
- A stalled D instruction is re-evaluated every cycle, with no lockout. The stall drops in the first cycle where the condition is false.
- `cnt` wrap: it never decrements below 0.
- Reset mid-count clears `cnt` to 0 immediately.

## Configuration
- `HAZARD_FWD_EN` defined: bypass network enabled as above.
- `HAZARD_FWD_EN` undefined:
  - All fwd outputs are tied to 0.
  - The stall condition becomes: E or M matches a read source, regardless of tnew.
  - W needs no stall because the regfile writes first.
- The MDU logic is identical in both builds.

## Test plan
- Load-use (FWD on): `lw $1` then `addu $3,$1,$2` (rs_tuse=1).
  - `stall`=1 for exactly 1 cycle.
  - Next cycle `fwd_rs_d`=0; one cycle later `fwd_rs_e`=3.
- ALU-branch: `addu $2` then `beq $2,$0` (tuse 0).
  - 1 stall cycle, then `fwd_rs_d`=2.
  - With `sw $2` instead: no stall, and later `fwd_rt_m`=3.
- MDU: `mult` then `mflo`.
  - `stall` high for 6 consecutive cycles (1+MULT_CYC).
  - `md_start` pulses once.
  - The same with `div` gives 11 cycles.
- Zero register: `lw $0` then `addu` reading `$0` → no stall, all fwd=0.
- Exception: `req`=1 while `lw $1` is in E and a `$1` consumer is in D.
  - Next cycle `stall`=0 and E/M/W hold bubbles.
  - A `mult` in E under `req` gives no `md_start`.
- FWD off: `addu $1` then `addu` reading `$1`.
  - `stall`=1 for 2 cycles, then 0.
  - All fwd outputs remain 0 throughout.
